// File: rtl/tx_fifo_streamer_if.sv
// ---------------------------------------------------------------------------
// tx_fifo_streamer_if
// Groups every non-clock/non-reset signal of tx_fifo_streamer.
//   Write side : data_tx, wren_fifo_tx           (master -> slave)
//   Control    : size_fifo_tx, start_tx, clr_err (master -> slave)
//   Status     : ready_tx, fifo_level,
//                err_overflow, err_short         (slave -> master)
//   Stream out : out_data, out_valid, out_sop,
//                out_eop                         (slave -> master)
//                out_ready                       (master -> slave)
// The streamer itself uses the slave modport; the driving side uses master.
// ---------------------------------------------------------------------------
interface tx_fifo_streamer_if;
  logic [7:0] data_tx;
  logic       wren_fifo_tx;
  logic [7:0] size_fifo_tx;
  logic       start_tx;
  logic       ready_tx;
  logic [8:0] fifo_level;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sop;
  logic       out_eop;
  logic       err_overflow;
  logic       err_short;
  logic       clr_err;

  modport slave (
    input  data_tx, wren_fifo_tx, size_fifo_tx, start_tx, out_ready, clr_err,
    output ready_tx, fifo_level, out_data, out_valid, out_sop, out_eop,
           err_overflow, err_short
  );

  modport master (
    output data_tx, wren_fifo_tx, size_fifo_tx, start_tx, out_ready, clr_err,
    input  ready_tx, fifo_level, out_data, out_valid, out_sop, out_eop,
           err_overflow, err_short
  );
endinterface

// File: rtl/tx_fifo_streamer.sv
// ---------------------------------------------------------------------------
// tx_fifo_streamer
// Byte FIFO that is filled continuously and drained as length-delimited
// packets onto a valid/ready byte stream with start/end-of-packet markers.
//   clk     : rising-edge system clock
//   reset_n : asynchronous, active-low reset
//   bus     : tx_fifo_streamer_if.slave (write port, packet control,
//             status/error flags, output stream)
// Parameter DEPTH: FIFO depth in bytes, power of two in 4..256.
// ---------------------------------------------------------------------------
module tx_fifo_streamer #(
  parameter int DEPTH = 256
) (
  input  logic               clk,
  input  logic               reset_n,
  tx_fifo_streamer_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [8:0]    LEVEL_FULL = 9'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;

  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [8:0]      level_r;
  logic [8:0]      level_s;
  logic [7:0]      rem_r;

  logic [7:0]      out_data_r;
  logic            out_valid_r;
  logic            out_sop_r;
  logic            out_eop_r;
  logic            err_overflow_r;
  logic            err_short_r;

  logic            xfer_s;
  logic            pop_s;
  logic            full_s;
  logic            wr_acc_s;
  logic            ovf_evt_s;
  logic            short_evt_s;
  logic            launch_s;
  logic            last_xfer_s;

  // FIFO occupancy and write acceptance; a pop in the same cycle frees a
  // slot, so a full FIFO can still take a byte while streaming.
  always_comb begin
    xfer_s    = out_valid_r & bus.out_ready;
    full_s    = (level_r == LEVEL_FULL);
    wr_acc_s  = bus.wren_fifo_tx & (~full_s | pop_s);
    ovf_evt_s = bus.wren_fifo_tx & full_s & ~pop_s;
    level_s   = level_r + 9'(wr_acc_s) - 9'(pop_s);
  end

  // Packet FSM next-state and per-cycle control strobes.
  always_comb begin
    state_s     = state_r;
    pop_s       = 1'b0;
    launch_s    = 1'b0;
    short_evt_s = 1'b0;
    last_xfer_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start_tx) begin
          if (bus.size_fifo_tx == 8'd0) begin
            state_s = ST_IDLE;
          end else if ({1'b0, bus.size_fifo_tx} > level_r) begin
            // Not enough bytes buffered: refuse the packet, touch nothing.
            short_evt_s = 1'b1;
            state_s     = ST_IDLE;
          end else begin
            launch_s = 1'b1;
            state_s  = ST_LOAD;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        pop_s   = 1'b1;
        state_s = ST_SEND;
      end
      ST_SEND: begin
        if (xfer_s) begin
          if (rem_r > 8'd1) begin
            // Refill the output register on the same edge: no bubble.
            pop_s   = 1'b1;
            state_s = ST_SEND;
          end else begin
            last_xfer_s = 1'b1;
            state_s     = ST_IDLE;
          end
        end else begin
          state_s = ST_SEND;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Read/write pointers (wrap naturally at DEPTH) and fill level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= 9'd0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_s;
    end
  end

  // Storage array; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem[wr_ptr_r] <= bus.data_tx;
    end
  end

  // Bytes of the current packet still to be transferred, counting the
  // one currently presented on out_data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_r <= 8'd0;
    end else if (launch_s) begin
      rem_r <= bus.size_fifo_tx;
    end else if (xfer_s) begin
      rem_r <= rem_r - 8'd1;
    end
  end

  // Registered output beat. eop is precomputed from the count that will be
  // left after this load so it lines up with the beat it marks.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data_r  <= 8'd0;
      out_valid_r <= 1'b0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
    end else if (pop_s) begin
      out_data_r  <= mem[rd_ptr_r];
      out_valid_r <= 1'b1;
      out_sop_r   <= (state_r == ST_LOAD);
      out_eop_r   <= (state_r == ST_LOAD) ? (rem_r == 8'd1) : (rem_r == 8'd2);
    end else if (last_xfer_s) begin
      out_valid_r <= 1'b0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
    end
  end

  // Sticky error flags; a new event wins over a coincident clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_overflow_r <= 1'b0;
      err_short_r    <= 1'b0;
    end else begin
      if (ovf_evt_s) begin
        err_overflow_r <= 1'b1;
      end else if (bus.clr_err) begin
        err_overflow_r <= 1'b0;
      end
      if (short_evt_s) begin
        err_short_r <= 1'b1;
      end else if (bus.clr_err) begin
        err_short_r <= 1'b0;
      end
    end
  end

  assign bus.ready_tx     = (state_r == ST_IDLE);
  assign bus.fifo_level   = level_r;
  assign bus.out_data     = out_data_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_sop      = out_sop_r;
  assign bus.out_eop      = out_eop_r;
  assign bus.err_overflow = err_overflow_r;
  assign bus.err_short    = err_short_r;

endmodule

// File: tb/tb_tx_fifo_streamer.sv
// ---------------------------------------------------------------------------
// tb_tx_fifo_streamer
// Directed bench for tx_fifo_streamer (DEPTH=16): a per-cycle vector table
// for basic packets and start/short-error handling, then hand-written
// sequences for stalls, full-FIFO/overflow/wrap, and mid-packet reset.
// ---------------------------------------------------------------------------
module tb_tx_fifo_streamer;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  tx_fifo_streamer_if bus();

  tx_fifo_streamer #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [7:0] expq[$];

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       start;
    logic [7:0] size;
    logic       ordy;
    logic       clr;
    logic       e_ready;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_sop;
    logic       e_eop;
    logic [8:0] e_level;
    logic       e_ov;
    logic       e_sh;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr, input logic [7:0] din, input logic start,
                              input logic [7:0] size, input logic ordy, input logic clr,
                              input logic e_ready, input logic e_valid, input logic [7:0] e_data,
                              input logic e_sop, input logic e_eop, input logic [8:0] e_level,
                              input logic e_ov, input logic e_sh);
    vec_t v;
    v.wr = wr; v.din = din; v.start = start; v.size = size; v.ordy = ordy; v.clr = clr;
    v.e_ready = e_ready; v.e_valid = e_valid; v.e_data = e_data; v.e_sop = e_sop;
    v.e_eop = e_eop; v.e_level = e_level; v.e_ov = e_ov; v.e_sh = e_sh;
    return v;
  endfunction

  // {ready, valid, data (only when valid), sop, eop, level, ov, short}
  function automatic logic [22:0] snap();
    return {bus.ready_tx, bus.out_valid, (bus.out_valid ? bus.out_data : 8'h00),
            bus.out_sop, bus.out_eop, bus.fifo_level, bus.err_overflow, bus.err_short};
  endfunction

  task automatic idle_inputs();
    bus.wren_fifo_tx = 1'b0;
    bus.data_tx      = 8'h00;
    bus.start_tx     = 1'b0;
    bus.size_fifo_tx = 8'h00;
    bus.clr_err      = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic clr);
    @(negedge clk);
    bus.wren_fifo_tx = 1'b1;
    bus.data_tx      = b;
    bus.clr_err      = clr;
    @(posedge clk);
    #1;
    bus.wren_fifo_tx = 1'b0;
    bus.clr_err      = 1'b0;
  endtask

  task automatic start_pkt(input logic [7:0] sz);
    @(negedge clk);
    bus.start_tx     = 1'b1;
    bus.size_fifo_tx = sz;
    @(posedge clk);
    #1;
    bus.start_tx     = 1'b0;
  endtask

  // Receive beats first..stop-1 of a len-byte packet with out_ready held high.
  task automatic recv(input int first, input int stop, input int len, input string tag);
    int idx;
    int guard;
    idx   = first;
    guard = 0;
    while (idx < stop && guard < 100) begin
      @(negedge clk);
      bus.wren_fifo_tx = 1'b0;
      bus.out_ready    = 1'b1;
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          check({tag, " model_empty"}, 32'd1, 32'd0);
        end else begin
          check({tag, " data"}, {24'd0, bus.out_data}, {24'd0, expq[0]});
          void'(expq.pop_front());
        end
        check({tag, " sop"}, {31'd0, bus.out_sop}, {31'd0, (idx == 0)});
        check({tag, " eop"}, {31'd0, bus.out_eop}, {31'd0, (idx == len - 1)});
        idx++;
      end
      guard++;
    end
    if (idx < stop) begin
      check({tag, " timeout"}, idx, stop);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0]  pat;
    logic [9:0]  held;
    logic        stalled;
    int          k;
    int          xf;
    int          extra;

    // ------------------------------------------------------------ reset
    reset_n       = 1'b0;
    bus.out_ready = 1'b0;
    idle_inputs();
    #3;
    check("reset_state", {9'd0, snap()}, {9'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0});
    check("reset_out_data", {24'd0, bus.out_data}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // ------------------------------------------------------------ vector table
    //             wr    din    st    size   ordy  clr   rdy   vld   data   sop   eop   level  ov    sh
    vecs.push_back(mk(1'b1, 8'h11, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h22, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd2, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'h33, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 9'd2, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 9'd1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 9'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'ha1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'ha2, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd2, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'ha3, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'ha4, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd4, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'ha5, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd5, 1'b0, 1'b0));
    // too-short request, then clear, then zero-length no-op
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'd6, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd5, 1'b0, 1'b1));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd5, 1'b0, 1'b0));
    // 5-byte packet; a write plus an ignored start land mid-packet
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'ha1, 1'b1, 1'b0, 9'd4, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 8'hb6, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b1, 8'ha2, 1'b0, 1'b0, 9'd4, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'ha3, 1'b0, 1'b0, 9'd3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'ha4, 1'b0, 1'b0, 9'd2, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'ha5, 1'b0, 1'b1, 9'd1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd1, 1'b0, 1'b0));
    // 1-byte packet: sop and eop on the same beat
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'd1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hb6, 1'b1, 1'b1, 9'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'd0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.wren_fifo_tx = vecs[i].wr;
      bus.data_tx      = vecs[i].din;
      bus.start_tx     = vecs[i].start;
      bus.size_fifo_tx = vecs[i].size;
      bus.out_ready    = vecs[i].ordy;
      bus.clr_err      = vecs[i].clr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {9'd0, snap()},
            {9'd0, vecs[i].e_ready, vecs[i].e_valid, (vecs[i].e_valid ? vecs[i].e_data : 8'h00),
             vecs[i].e_sop, vecs[i].e_eop, vecs[i].e_level, vecs[i].e_ov, vecs[i].e_sh});
    end
    @(negedge clk);
    idle_inputs();
    bus.out_ready = 1'b0;

    // ------------------------------------------------------------ stall pattern
    for (int i = 0; i < 4; i++) begin
      write_byte(8'h41 + 8'(i), 1'b0);
    end
    start_pkt(8'd4);
    pat     = 4'b1001;
    k       = 0;
    xf      = 0;
    stalled = 1'b0;
    held    = 10'd0;
    for (int cyc = 0; cyc < 40 && xf < 4; cyc++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (stalled) begin
          check("stall_hold", {22'd0, bus.out_data, bus.out_sop, bus.out_eop}, {22'd0, held});
        end
        bus.out_ready = pat[k[1:0]];
        k++;
        if (bus.out_ready) begin
          check("stall_data", {24'd0, bus.out_data}, {24'd0, 8'h41 + 8'(xf)});
          check("stall_sop", {31'd0, bus.out_sop}, {31'd0, (xf == 0)});
          check("stall_eop", {31'd0, bus.out_eop}, {31'd0, (xf == 3)});
          xf++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = {bus.out_data, bus.out_sop, bus.out_eop};
        end
      end else begin
        bus.out_ready = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        extra++;
      end
    end
    check("stall_count", xf, 32'd4);
    check("stall_no_extra", extra, 32'd0);
    check("stall_end_state", {9'd0, snap()}, {9'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0});
    bus.out_ready = 1'b0;

    // ------------------------------------------------------------ full, overflow, wrap
    expq.delete();
    for (int i = 0; i < DEPTH; i++) begin
      write_byte(8'(i * 7 + 3), 1'b0);
      expq.push_back(8'(i * 7 + 3));
    end
    check("full_level", {23'd0, bus.fifo_level}, 32'd16);
    check("full_no_ovf", {31'd0, bus.err_overflow}, 32'd0);
    write_byte(8'hee, 1'b0);
    check("ovf_set", {30'd0, bus.err_overflow, bus.err_short}, 32'b10);
    check("ovf_level", {23'd0, bus.fifo_level}, 32'd16);
    write_byte(8'hef, 1'b1);
    check("ovf_set_wins", {31'd0, bus.err_overflow}, 32'd1);
    @(negedge clk);
    bus.clr_err = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_err = 1'b0;
    check("ovf_cleared", {31'd0, bus.err_overflow}, 32'd0);

    start_pkt(8'd16);
    check("load_not_ready", {31'd0, bus.ready_tx}, 32'd0);
    @(posedge clk);
    #1;
    check("first_beat", {9'd0, snap()},
          {9'd0, 1'b0, 1'b1, expq[0], 1'b1, 1'b0, 9'd15, 1'b0, 1'b0});
    write_byte(8'hc0, 1'b0);
    expq.push_back(8'hc0);
    check("refill_level", {23'd0, bus.fifo_level}, 32'd16);
    @(negedge clk);
    check("full_beat0", {24'd0, bus.out_data}, {24'd0, expq[0]});
    void'(expq.pop_front());
    bus.wren_fifo_tx = 1'b1;
    bus.data_tx      = 8'hc1;
    bus.out_ready    = 1'b1;
    @(posedge clk);
    #1;
    bus.wren_fifo_tx = 1'b0;
    bus.out_ready    = 1'b0;
    expq.push_back(8'hc1);
    check("full_wr_pop", {22'd0, bus.fifo_level, bus.err_overflow}, {22'd0, 9'd16, 1'b0});
    recv(1, 16, 16, "full_pkt");
    bus.out_ready = 1'b0;
    check("full_pkt_end", {9'd0, snap()}, {9'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd2, 1'b0, 1'b0});
    start_pkt(8'd2);
    recv(0, 2, 2, "tail_pkt");
    bus.out_ready = 1'b0;
    check("tail_end", {9'd0, snap()}, {9'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0});

    // ------------------------------------------------------------ mid-packet reset
    expq.delete();
    for (int i = 0; i < 4; i++) begin
      write_byte(8'h51 + 8'(i), 1'b0);
      expq.push_back(8'h51 + 8'(i));
    end
    start_pkt(8'd4);
    recv(0, 2, 4, "rst_pkt");
    check("pre_reset_busy", {31'd0, bus.out_valid}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset", {9'd0, snap()}, {9'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0});
    check("async_reset_data", {24'd0, bus.out_data}, 32'd0);
    expq.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset%0d", i), {9'd0, snap()},
            {9'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 9'd0, 1'b0, 1'b0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/tx_fifo_streamer.md
TX_FIFO_STREAMER -- requirements
Module: tx_fifo_streamer

Interface
REQ-001 Parameter DEPTH, default 256, FIFO depth in bytes (power of 2, 4..256).
REQ-002 clk  input  1  system clock; all logic is sampled on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 data_tx  input  8  byte to enqueue.
REQ-005 wren_fifo_tx  input  1  enqueue strobe, one byte per cycle high.
REQ-006 size_fifo_tx  input  8  packet length in bytes, sampled at start.
REQ-007 start_tx  input  1  packet start request.
REQ-008 ready_tx  output  1  high when IDLE and able to accept start_tx.
REQ-009 fifo_level  output  9  bytes currently stored (0..DEPTH).
REQ-010 out_data  output  8  streamed byte.
REQ-011 out_valid  output  1  out_data valid.
REQ-012 out_ready  input  1  sink accepts; a transfer occurs when out_valid and out_ready are both high.
REQ-013 out_sop / out_eop  output  1 each  first / last byte of packet, qualified by out_valid.
REQ-014 err_overflow / err_short  output  1 each  sticky error flags.
REQ-015 clr_err  input  1  clears both sticky flags.

Function
REQ-016 FIFO: circular buffer with ptr wrap at DEPTH; fifo_level = writes accepted - bytes popped.
REQ-017 A write is accepted when wren_fifo_tx is high and either fifo_level < DEPTH or a pop occurs in the same cycle.
REQ-018 A write to a full FIFO with no same-cycle pop drops the byte, sets err_overflow, and leaves level and pointers unchanged.
REQ-019 Writes are accepted in every state.
REQ-020 FSM states: IDLE, LOAD, SEND.
- ready_tx = (state==IDLE).
REQ-021 IDLE, start_tx=1, size_fifo_tx=0: no-op; remains IDLE.
REQ-022 IDLE, start_tx=1, size_fifo_tx > fifo_level: rejected; err_short set; remains IDLE; no bytes consumed.
REQ-023 IDLE, start_tx=1, 0 < size_fifo_tx <= fifo_level:
- latch length into remaining counter;
- go to LOAD.
REQ-024 LOAD (1 cycle): pop head byte into the output register, set out_valid=1 and out_sop=1, and go to SEND.
- Result: out_valid rises 2 cycles after the start_tx cycle.
REQ-025 SEND: out_data, out_valid, out_sop and out_eop hold stable while out_valid=1 and out_ready=0.
REQ-026 SEND, on each transfer, remaining decrements.
- If remaining was >1: pop the next byte into the output register in the same cycle, so back-to-back transfers are possible with no bubble; out_sop=0.
- If remaining was 1: out_valid=0 next cycle; go to IDLE.
REQ-027 out_eop = out_valid and remaining==1.
- A 1-byte packet has out_sop=out_eop=1 on the same beat.
REQ-028 start_tx outside IDLE is ignored, with no error.
REQ-029 A same-cycle write and pop leaves fifo_level unchanged; data ordering is strictly FIFO.
REQ-030 clr_err clears the flags. If clr_err coincides with a new error event, the flag is set (set wins).
REQ-031 Read data is registered; there is no combinational path from out_ready to out_valid or out_data.

Reset
REQ-032 reset_n low asynchronously forces:
- state=IDLE; pointers, level and remaining=0;
- out_valid, out_sop, out_eop, err_overflow, err_short = 0; out_data=0;
- ready_tx=1.
REQ-033 Reset mid-packet discards the FIFO contents and the packet; no partial burst continues after release.
REQ-034 FIFO memory contents need not be cleared by reset.

Verification
REQ-035 Write 0x11,0x22,0x33 then start_tx, size=3, out_ready=1 -> out_valid at start+2; bytes 11,22,33 on consecutive cycles; sop on 11, eop on 33; ready_tx returns 1; fifo_level=0.
REQ-036 Fill 5 bytes, start size=6 -> err_short=1, ready_tx stays 1, fifo_level=5; clr_err -> err_short=0.
REQ-037 Fill DEPTH bytes, one more write with no pop -> err_overflow=1, fifo_level=DEPTH; streaming DEPTH bytes returns them in original order, including pointer wrap.
REQ-038 Packet size=4 with out_ready toggled 1,0,0,1,... -> each byte held stable while stalled; exactly 4 transfers; eop on the 4th.
REQ-039 Full FIFO in SEND, simultaneous write and pop -> write accepted, no overflow, fifo_level stays DEPTH.
REQ-040 Assert reset_n=0 after the 2nd of 4 bytes -> outputs take reset values immediately; after release, fifo_level=0, out_valid=0, ready_tx=1.
